// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake and display-drive bundle between a content producer and seven_seg_scan_ctrl.
// The master supplies display contents; the slave (scan controller) drives the decoder and anodes.
interface seven_seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 2
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] load_digits;
   logic [NUM_DIGITS-1:0]   load_en;
   logic [3:0]              hex_sel;
   logic [NUM_DIGITS-1:0]   an_n;
   logic [IDX_W-1:0]        digit_idx;
   logic                    frame_done;

   modport master (
      output load_valid, load_digits, load_en,
      input  load_ready, hex_sel, an_n, digit_idx, frame_done
   );

   modport slave (
      input  load_valid, load_digits, load_en,
      output load_ready, hex_sel, an_n, digit_idx, frame_done
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with blanking gaps and
// frame-synchronous double-buffered content loading.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 2,
   parameter int DWELL_CYCLES = 24000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   seven_seg_scan_ctrl_if.slave  bus
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int MAX_C = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
   localparam int DW    = 4 * NUM_DIGITS;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DW-1:0]         pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
   logic                  pend_flag_q, pend_flag_d;
   logic [DW-1:0]         shadow_dig_q, shadow_dig_d;
   logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
   logic                  boundary_s;
   logic                  xfer_s;

   logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
   logic [3:0]            hex_sel_q, hex_sel_d;
   logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
   logic                  frame_done_q, frame_done_d;
   logic                  load_ready_q, load_ready_d;

   // State, buffers and registered outputs; reset blanks the display and drops any pending load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_dig_q   <= '0;
         pend_en_q    <= '0;
         pend_flag_q  <= 1'b0;
         shadow_dig_q <= '0;
         shadow_en_q  <= '0;
         an_n_q       <= '1;
         hex_sel_q    <= 4'h0;
         digit_idx_q  <= '0;
         frame_done_q <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_dig_q   <= pend_dig_d;
         pend_en_q    <= pend_en_d;
         pend_flag_q  <= pend_flag_d;
         shadow_dig_q <= shadow_dig_d;
         shadow_en_q  <= shadow_en_d;
         an_n_q       <= an_n_d;
         hex_sel_q    <= hex_sel_d;
         digit_idx_q  <= digit_idx_d;
         frame_done_q <= frame_done_d;
         load_ready_q <= load_ready_d;
      end
   end

   // Next-state: blank/drive sequencing, digit advance, handshake capture and frame-boundary swap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      idx_d      = idx_q;
      boundary_s = 1'b0;
      case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
               state_d = ST_DRIVE;
               cnt_d   = '0;
            end else begin
               state_d = ST_BLANK;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                  idx_d      = '0;
                  boundary_s = 1'b1;
               end else begin
                  idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
               end
            end else begin
               state_d = ST_DRIVE;
            end
         end
         default: begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // load_ready already excludes a pending load, so capture and swap never collide.
      xfer_s       = bus.load_valid & load_ready_q;
      shadow_dig_d = shadow_dig_q;
      shadow_en_d  = shadow_en_q;
      pend_dig_d   = pend_dig_q;
      pend_en_d    = pend_en_q;
      pend_flag_d  = pend_flag_q;
      if (boundary_s && pend_flag_q) begin
         shadow_dig_d = pend_dig_q;
         shadow_en_d  = pend_en_q;
         pend_flag_d  = 1'b0;
      end else if (boundary_s) begin
         pend_flag_d = 1'b0;
      end else begin
         pend_flag_d = pend_flag_q;
      end
      if (xfer_s) begin
         pend_dig_d  = bus.load_digits;
         pend_en_d   = bus.load_en;
         pend_flag_d = 1'b1;
      end else begin
         pend_dig_d = pend_dig_q;
      end
   end

   // Output decode from next-state values so every output is a plain register.
   always_comb begin
      an_n_d       = '1;
      hex_sel_d    = 4'h0;
      digit_idx_d  = idx_d;
      frame_done_d = boundary_s;
      // Ready stays low for the cycle after a swap, then follows the pending flag.
      load_ready_d = ~pend_flag_d & ~(boundary_s & pend_flag_q);
      if (int'(idx_d) < NUM_DIGITS) begin
         hex_sel_d = shadow_dig_d[4*int'(idx_d) +: 4];
         if (state_d == ST_DRIVE) begin
            an_n_d[idx_d] = ~shadow_en_d[idx_d];
         end else begin
            an_n_d = '1;
         end
      end else begin
         hex_sel_d = 4'h0;
         an_n_d    = '1;
      end
   end

   assign bus.an_n       = an_n_q;
   assign bus.hex_sel    = hex_sel_q;
   assign bus.digit_idx  = digit_idx_q;
   assign bus.frame_done = frame_done_q;
   assign bus.load_ready = load_ready_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: directed scenarios plus random load traffic
// compared against a frame-position reference model.
module tb_seven_seg_scan_ctrl;
   localparam int ND = 2;
   localparam int D  = 4;
   localparam int B  = 2;
   localparam int SL = B + D;
   localparam int P  = ND * SL;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   int   t = 0;

   // Reference model: contents shown in the current frame and the one waiting for the next.
   logic       m_flag, m_ready;
   logic [7:0] m_pdig, m_sdig;
   logic [1:0] m_pen, m_sen;

   seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS(ND), .DWELL_CYCLES(D), .BLANK_CYCLES(B)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic int cur_digit();
      return (t % P) / SL;
   endfunction

   function automatic logic [1:0] exp_an();
      int dg = cur_digit();
      bit drv = ((t % P) % SL) >= B;
      logic [1:0] one = 2'b01;
      if (drv && m_sen[dg]) return ~(one << dg);
      return 2'b11;
   endfunction

   function automatic logic [3:0] exp_hex();
      return m_sdig[cur_digit()*4 +: 4];
   endfunction

   function automatic logic exp_fd();
      return (t > 0) && ((t % P) == 0);
   endfunction

   task automatic model_reset();
      m_flag = 1'b0; m_ready = 1'b1;
      m_pdig = 8'h00; m_sdig = 8'h00; m_pen = 2'b00; m_sen = 2'b00;
      t = 0;
   endtask

   task automatic do_reset();
      bus.load_valid = 1'b0; bus.load_digits = 8'h00; bus.load_en = 2'b00;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Present one cycle of inputs, advance the model across the edge, return at the next negedge.
   task automatic step(input logic v, input logic [7:0] d, input logic [1:0] e);
      int pos; bit bnd, xfer, old_flag;
      bus.load_valid = v; bus.load_digits = d; bus.load_en = e;
      @(posedge clk);
      pos = t % P; bnd = (pos == P - 1); xfer = v && m_ready; old_flag = m_flag;
      if (bnd && old_flag) begin m_sdig = m_pdig; m_sen = m_pen; end
      if (bnd) m_flag = 1'b0;
      if (xfer) begin m_pdig = d; m_pen = e; m_flag = 1'b1; end
      m_ready = !m_flag && !(bnd && old_flag);
      t++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_assert++; if (bus.an_n !== 2'b11) begin n_fail++; $display("FAIL reset_an_n got %b want 11", bus.an_n); end
      n_assert++; if (bus.hex_sel !== 4'h0) begin n_fail++; $display("FAIL reset_hex got %h want 0", bus.hex_sel); end
      n_assert++; if (bus.digit_idx !== 1'b0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", bus.digit_idx); end
      n_assert++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
      n_assert++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.load_ready); end
   endtask

   task automatic test_idle_scan();
      do_reset();
      for (int c = 0; c < 3*P; c++) begin
         n_assert++; if (bus.an_n !== 2'b11) begin n_fail++; $display("FAIL idle_an_n c=%0d got %b want 11", c, bus.an_n); end
         n_assert++; if (bus.digit_idx !== 1'((c % P) >= SL)) begin n_fail++; $display("FAIL idle_idx c=%0d got %0d", c, bus.digit_idx); end
         n_assert++; if (bus.frame_done !== 1'(c > 0 && (c % P) == 0)) begin n_fail++; $display("FAIL idle_fd c=%0d got %b", c, bus.frame_done); end
         step(1'b0, 8'h00, 2'b00);
      end
   endtask

   task automatic test_load();
      logic [1:0] w_an; logic [3:0] w_hex;
      do_reset();
      for (int c = 0; c < 26; c++) begin
         w_an = 2'b11; w_hex = bus.hex_sel;
         if (c >= 14 && c <= 17) begin w_an = 2'b10; w_hex = 4'h5; end
         if (c >= 20 && c <= 23) begin w_an = 2'b01; w_hex = 4'hA; end
         n_assert++; if (bus.load_ready !== 1'(!(c >= 4 && c <= 12))) begin n_fail++; $display("FAIL load_ready c=%0d got %b", c, bus.load_ready); end
         n_assert++; if (bus.an_n !== w_an) begin n_fail++; $display("FAIL load_an_n c=%0d got %b want %b", c, bus.an_n, w_an); end
         n_assert++; if (bus.hex_sel !== w_hex) begin n_fail++; $display("FAIL load_hex c=%0d got %h want %h", c, bus.hex_sel, w_hex); end
         step(c == 3, 8'hA5, 2'b11);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(1'b1, 8'hA5, 2'b11);
      for (int c = 1; c < 40; c++) begin
         n_assert++; if (bus.load_ready !== m_ready) begin n_fail++; $display("FAIL b2b_ready c=%0d got %b want %b", c, bus.load_ready, m_ready); end
         n_assert++; if (bus.an_n !== exp_an()) begin n_fail++; $display("FAIL b2b_an_n c=%0d got %b want %b", c, bus.an_n, exp_an()); end
         n_assert++; if (bus.hex_sel !== exp_hex()) begin n_fail++; $display("FAIL b2b_hex c=%0d got %h want %h", c, bus.hex_sel, exp_hex()); end
         if (c == 15 || c == 22 || c == 27 || c == 33) begin
            n_assert++;
            if (bus.hex_sel !== ((c < 24) ? ((c < 18) ? 4'h5 : 4'hA) : ((c < 30) ? 4'hC : 4'h3))) begin
               n_fail++; $display("FAIL b2b_frame_contents c=%0d got %h", c, bus.hex_sel);
            end
         end
         step(1'b1, 8'h3C, 2'b11);
      end
   endtask

   task automatic test_partial_enable();
      do_reset();
      step(1'b1, 8'h77, 2'b01);
      for (int c = 1; c < 26; c++) begin
         if (c >= 12 && c <= 23) begin
            n_assert++; if (bus.an_n !== ((c >= 14 && c <= 17) ? 2'b10 : 2'b11)) begin n_fail++; $display("FAIL part_an_n c=%0d got %b", c, bus.an_n); end
            n_assert++; if (bus.hex_sel !== 4'h7) begin n_fail++; $display("FAIL part_hex c=%0d got %h want 7", c, bus.hex_sel); end
         end
         step(1'b0, 8'h00, 2'b00);
      end
   endtask

   task automatic test_reset_midframe();
      do_reset();
      step(1'b1, 8'hA5, 2'b11);
      for (int c = 1; c < 16; c++) step(c == 13, 8'h3C, 2'b11);
      n_assert++; if (bus.an_n !== 2'b10) begin n_fail++; $display("FAIL mid_pre_an_n got %b want 10", bus.an_n); end
      #2 reset = 1'b1;
      #1;
      n_assert++; if (bus.an_n !== 2'b11) begin n_fail++; $display("FAIL mid_async_an_n got %b want 11", bus.an_n); end
      n_assert++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_ready got %b want 1", bus.load_ready); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int c = 0; c < 3*P; c++) begin
         n_assert++; if (bus.an_n !== 2'b11) begin n_fail++; $display("FAIL mid_dark_an_n c=%0d got %b", c, bus.an_n); end
         n_assert++; if (bus.load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready c=%0d got %b", c, bus.load_ready); end
         step(1'b0, 8'h00, 2'b00);
      end
   endtask

   task automatic test_random();
      logic [3:0] prev_hex;
      logic [1:0] on;
      do_reset();
      prev_hex = bus.hex_sel;
      for (int c = 0; c < 1000*P; c++) begin
         on = ~bus.an_n;
         n_assert++; if ((on & (on - 2'b01)) !== 2'b00) begin n_fail++; $display("FAIL rnd_onehot c=%0d an_n=%b", c, bus.an_n); end
         n_assert++; if (bus.an_n !== exp_an()) begin n_fail++; $display("FAIL rnd_an_n c=%0d got %b want %b", c, bus.an_n, exp_an()); end
         n_assert++; if (bus.hex_sel !== exp_hex()) begin n_fail++; $display("FAIL rnd_hex c=%0d got %h want %h", c, bus.hex_sel, exp_hex()); end
         n_assert++; if (bus.digit_idx !== 1'(cur_digit())) begin n_fail++; $display("FAIL rnd_idx c=%0d got %0d want %0d", c, bus.digit_idx, cur_digit()); end
         n_assert++; if (bus.frame_done !== exp_fd()) begin n_fail++; $display("FAIL rnd_fd c=%0d got %b want %b", c, bus.frame_done, exp_fd()); end
         n_assert++; if (bus.load_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.load_ready, m_ready); end
         if ((t % SL) != 0) begin
            n_assert++; if (bus.hex_sel !== prev_hex) begin n_fail++; $display("FAIL rnd_stable c=%0d got %h want %h", c, bus.hex_sel, prev_hex); end
         end
         prev_hex = bus.hex_sel;
         step(($urandom_range(0, 7) == 0), 8'($urandom), 2'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_load();
      test_back_to_back();
      test_partial_enable();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
